// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared widths, ALU op codes and operand-select encodings
package alu_issue_pkg;
  localparam int XLEN = 32;
  localparam int OP_W = 5;
  localparam int RAW = 5;
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLL  = 5'd2,
    OP_REMU = 5'd3,
    OP_AND  = 5'd4,
    OP_OR   = 5'd5,
    OP_XOR  = 5'd6
  } alu_op_e;
  localparam logic SRC1_RS1 = 1'b0;
  localparam logic SRC1_PC  = 1'b1;
  localparam logic SRC2_RS2 = 1'b0;
  localparam logic SRC2_IMM = 1'b1;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: decode-side request and ALU-side result handshake bundle
interface alu_issue_if;
  import alu_issue_pkg::*;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_pc;
  logic [RAW-1:0]  in_rs1_addr;
  logic [RAW-1:0]  in_rs2_addr;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic [XLEN-1:0] in_imm;
  logic [OP_W-1:0] in_op;
  logic            in_src1_sel;
  logic            in_src2_sel;
  logic [RAW-1:0]  in_rd_addr;
  logic            in_rd_we;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] ip1;
  logic [XLEN-1:0] ip2;
  logic [OP_W-1:0] operation;
  logic [RAW-1:0]  out_rd_addr;
  logic            out_rd_we;
  modport slave (
    input  in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_op, in_src1_sel, in_src2_sel, in_rd_addr, in_rd_we, out_ready,
    output in_ready, out_valid, ip1, ip2, operation, out_rd_addr, out_rd_we
  );
  modport master (
    output in_valid, in_pc, in_rs1_addr, in_rs2_addr, in_rs1_data, in_rs2_data,
           in_imm, in_op, in_src1_sel, in_src2_sel, in_rd_addr, in_rd_we, out_ready,
    input  in_ready, out_valid, ip1, ip2, operation, out_rd_addr, out_rd_we
  );
endinterface

// File: rtl/alu_issue_stage_fwd_mux.sv
// alu_fwd_mux: per-operand bypass select, EX (younger) over WB over register file
module alu_fwd_mux
  import alu_issue_pkg::*;
(
  input  logic [RAW-1:0]  rs,
  input  logic [XLEN-1:0] rs_data,
  input  logic            ex_we,
  input  logic [RAW-1:0]  ex_rd,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] val
);
  // x0 never matches because the rd != 0 guard excludes it; load data in EX is not ready yet
  always_comb
    val = (ex_we && ex_rd != '0 && ex_rd == rs && !ex_is_load) ? ex_data :
          (wb_we && wb_rd != '0 && wb_rd == rs) ? wb_data : rs_data;
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register with operand select, forwarding and load-use stall
module alu_issue_stage
  import alu_issue_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  alu_issue_if.slave      io,
  input  logic            flush,
  input  logic            ex_we,
  input  logic [RAW-1:0]  ex_rd,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_data,
  input  logic            wb_we,
  input  logic [RAW-1:0]  wb_rd,
  input  logic [XLEN-1:0] wb_data
);
  logic            hz, rdy, accept;
  logic [XLEN-1:0] fwd1, fwd2;
  logic            valid_q, valid_d, we_q, we_d;
  logic [XLEN-1:0] ip1_q, ip1_d, ip2_q, ip2_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [RAW-1:0]  rd_q, rd_d;
  alu_fwd_mux u_fwd1 (
    .rs(io.in_rs1_addr), .rs_data(io.in_rs1_data),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .val(fwd1)
  );
  alu_fwd_mux u_fwd2 (
    .rs(io.in_rs2_addr), .rs_data(io.in_rs2_data),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .val(fwd2)
  );
  // hazard/handshake decode and next register contents; flush beats accept and hold
  always_comb begin
    hz = ex_we && ex_is_load && ex_rd != '0 &&
         ((io.in_src1_sel == SRC1_RS1 && ex_rd == io.in_rs1_addr) ||
          (io.in_src2_sel == SRC2_RS2 && ex_rd == io.in_rs2_addr));
    rdy = (!valid_q || io.out_ready) && !hz;
    accept = io.in_valid && rdy && !flush;
    valid_d = !flush && (accept || (valid_q && !io.out_ready));
    ip1_d = accept ? (io.in_src1_sel == SRC1_PC ? io.in_pc : fwd1) : ip1_q;
    ip2_d = accept ? (io.in_src2_sel == SRC2_IMM ? io.in_imm : fwd2) : ip2_q;
    op_d = accept ? io.in_op : op_q;
    rd_d = accept ? io.in_rd_addr : rd_q;
    we_d = accept ? io.in_rd_we : we_q;
  end
  // single-entry output register, cleared asynchronously
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_q <= 1'b0;
      ip1_q <= '0;
      ip2_q <= '0;
      op_q <= '0;
      rd_q <= '0;
      we_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      ip1_q <= ip1_d;
      ip2_q <= ip2_d;
      op_q <= op_d;
      rd_q <= rd_d;
      we_q <= we_d;
    end
  assign io.in_ready = rdy;
  assign io.out_valid = valid_q;
  assign io.ip1 = ip1_q;
  assign io.ip2 = ip2_q;
  assign io.operation = op_q;
  assign io.out_rd_addr = rd_q;
  assign io.out_rd_we = we_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed scoreboard bench for the ALU issue stage
module tb_alu_issue_stage;
  import alu_issue_pkg::*;
  typedef struct {
    logic [XLEN-1:0] ip1;
    logic [XLEN-1:0] ip2;
    logic [OP_W-1:0] op;
    logic [RAW-1:0]  rd;
    logic            we;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic ex_we, ex_is_load, wb_we;
  logic [RAW-1:0] ex_rd, wb_rd;
  logic [XLEN-1:0] ex_data, wb_data;
  exp_t sb[$];
  int tests = 0, fails = 0;
  alu_issue_if io ();
  alu_issue_stage dut (
    .clk(clk), .rst(rst), .io(io), .flush(flush),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_data(ex_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drv(logic v, logic [31:0] pc, logic [4:0] r1, logic [4:0] r2,
                     logic [31:0] d1, logic [31:0] d2, logic [31:0] imm, logic [4:0] op,
                     logic s1, logic s2, logic [4:0] rd, logic we);
    io.in_valid = v; io.in_pc = pc; io.in_rs1_addr = r1; io.in_rs2_addr = r2;
    io.in_rs1_data = d1; io.in_rs2_data = d2; io.in_imm = imm; io.in_op = op;
    io.in_src1_sel = s1; io.in_src2_sel = s2; io.in_rd_addr = rd; io.in_rd_we = we;
  endtask
  task automatic fw(logic ew, logic [4:0] er, logic el, logic [31:0] ed,
                    logic ww, logic [4:0] wr, logic [31:0] wd);
    ex_we = ew; ex_rd = er; ex_is_load = el; ex_data = ed;
    wb_we = ww; wb_rd = wr; wb_data = wd;
  endtask
  task automatic push(logic [31:0] a, logic [31:0] b, logic [4:0] op, logic [4:0] rd, logic we);
    exp_t e;
    e.ip1 = a; e.ip2 = b; e.op = op; e.rd = rd; e.we = we;
    sb.push_back(e);
  endtask
  // every transfer the ALU sees must match the oldest expected entry
  always @(negedge clk)
    if (!rst && io.out_valid && io.out_ready) begin
      chk("sb_nonempty", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_ip1", io.ip1, e.ip1);
        chk("sb_ip2", io.ip2, e.ip2);
        chk("sb_op", io.operation, e.op);
        chk("sb_rd", io.out_rd_addr, e.rd);
        chk("sb_we", io.out_rd_we, e.we);
      end
    end
  initial begin
    io.out_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    fw(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_valid", io.out_valid, 0);
    chk("rst_ip1", io.ip1, 0);
    chk("rst_ip2", io.ip2, 0);
    chk("rst_op", io.operation, 0);
    chk("rst_rd", io.out_rd_addr, 0);
    chk("rst_we", io.out_rd_we, 0);
    rst = 1'b0;
    io.out_ready = 1'b0;
    drv(1, 32'h100, 1, 2, 5, 6, 0, OP_SUB, 0, 0, 3, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    chk("hold_valid", io.out_valid, 1);
    chk("hold_ip1", io.ip1, 5);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", io.out_valid, 0);
    chk("async_rst_ip1", io.ip1, 0);
    chk("async_rst_op", io.operation, 0);
    tick();
    rst = 1'b0;
    io.out_ready = 1'b1;
    drv(1, 32'h104, 1, 2, 23, 46, 0, OP_ADD, 0, 0, 7, 1);
    push(23, 46, OP_ADD, 7, 1);
    #1 chk("plain_in_ready", io.in_ready, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    chk("plain_valid", io.out_valid, 1);
    chk("plain_ip1", io.ip1, 23);
    chk("plain_ip2", io.ip2, 46);
    chk("plain_op", io.operation, OP_ADD);
    tick();
    chk("bubble_valid", io.out_valid, 0);
    chk("bubble_ip1_kept", io.ip1, 23);
    fw(1, 3, 0, 128, 1, 3, 7);
    drv(1, 32'h108, 3, 4, 1, 2, 0, OP_SUB, 0, 0, 8, 1);
    push(128, 2, OP_SUB, 8, 1);
    tick();
    fw(1, 9, 0, 32'hdead, 1, 4, 59);
    drv(1, 32'h10c, 6, 4, 10, 11, 0, OP_XOR, 0, 0, 9, 1);
    push(10, 59, OP_XOR, 9, 1);
    tick();
    fw(1, 0, 0, 128, 1, 0, 7);
    drv(1, 32'h110, 0, 0, 32'h11, 32'h22, 0, OP_OR, 0, 0, 10, 1);
    push(32'h11, 32'h22, OP_OR, 10, 1);
    tick();
    fw(1, 3, 0, 128, 1, 3, 7);
    drv(1, 32'h200, 3, 3, 1, 2, 32'h44, OP_AND, 1, 1, 11, 1);
    push(32'h200, 32'h44, OP_AND, 11, 1);
    tick();
    fw(1, 5, 1, 32'h77, 0, 0, 0);
    drv(1, 32'h204, 1, 5, 32'h30, 32'h31, 0, OP_SLL, 0, 0, 12, 1);
    #1 chk("lu_in_ready", io.in_ready, 0);
    tick();
    chk("lu_bubble", io.out_valid, 0);
    chk("lu_still_stalled", io.in_ready, 0);
    fw(0, 5, 0, 0, 1, 5, 32'h99);
    push(32'h30, 32'h99, OP_SLL, 12, 1);
    #1 chk("lu_release", io.in_ready, 1);
    tick();
    fw(1, 1, 0, 32'hc0, 0, 0, 0);
    drv(1, 32'h208, 1, 2, 3, 4, 0, OP_REMU, 0, 0, 13, 1);
    push(32'hc0, 4, OP_REMU, 13, 1);
    tick();
    io.out_ready = 1'b0;
    drv(1, 32'h20c, 6, 7, 32'h60, 32'h70, 0, OP_ADD, 0, 0, 14, 0);
    for (int i = 0; i < 3; i++) begin
      ex_data = 32'hc1 + i;
      #1;
      chk("bp_in_ready", io.in_ready, 0);
      chk("bp_valid", io.out_valid, 1);
      chk("bp_ip1", io.ip1, 32'hc0);
      chk("bp_ip2", io.ip2, 4);
      tick();
    end
    io.out_ready = 1'b1;
    #1 chk("bp_release", io.in_ready, 1);
    push(32'h60, 32'h70, OP_ADD, 14, 0);
    tick();
    chk("bp_next_valid", io.out_valid, 1);
    chk("bp_next_ip1", io.ip1, 32'h60);
    drv(1, 32'h210, 1, 2, 32'he1, 32'he2, 0, OP_SUB, 0, 0, 15, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, OP_ADD, 0, 0, 0, 0);
    chk("flush_valid", io.out_valid, 0);
    tick();
    chk("flush_stays_empty", io.out_valid, 0);
    tick();
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
